op_sequencer: RTL and testbench

OP_SEQUENCER -- requirements
Module: op_sequencer

---
 rtl/op_seq_pkg.sv | 23 ++
 rtl/op_sequencer_if.sv | 34 +++
 rtl/op_fifo.sv | 63 ++++++
 rtl/op_sequencer.sv | 152 +++++++++++++++
 tb/tb_op_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/op_seq_pkg.sv
// Shared definitions for the operation sequencer.
// Contents:
//   F_W, R_W - widths of the function and routing fields
//   state_t  - sequencer FSM states (IDLE, SHIFT, DONE, HOLD)
//   cmd_t    - one queued command entry {f, r}
package op_seq_pkg;

    localparam int F_W = 3;
    localparam int R_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [F_W-1:0] f;
        logic [R_W-1:0] r;
    } cmd_t;

endpackage

// File: rtl/op_sequencer_if.sv
// Command push channel into the operation sequencer.
// Signals:
//   cmd_valid - producer offers an entry {cmd_F, cmd_R}
//   cmd_ready - sequencer queue has room
//   cmd_F     - function select of the offered entry
//   cmd_R     - routing select of the offered entry
// Handshake: an entry is taken on a rising clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready does not depend on cmd_valid. An offer
// made while cmd_ready is low is simply not taken (the entry is dropped,
// nothing inside the sequencer changes); the producer may hold or withdraw it.
// Modports: master = producer, slave = sequencer.
interface op_sequencer_if;
    import op_seq_pkg::*;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [F_W-1:0] cmd_F;
    logic [R_W-1:0] cmd_R;

    modport master (
        output cmd_valid,
        output cmd_F,
        output cmd_R,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_F,
        input  cmd_R,
        output cmd_ready
    );

endinterface

// File: rtl/op_fifo.sv
// DEPTH-entry circular command buffer with wrap-around pointers.
// Ports:
//   Clk, Reset - clock, synchronous active-high reset (flushes the buffer)
//   push, din  - write din at the tail (ignored when full or in reset)
//   pop        - discard the head entry (ignored when empty)
//   head       - current head entry (meaningful only when count != 0)
//   count      - number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module op_fifo
    import op_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     din,
    output cmd_t                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    // Storage has no reset; a write during reset is blocked so the flush is clean.
    always_ff @(posedge Clk) begin
        if (!Reset && do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Operation sequencer: queues {F, R} commands and, on an Execute press,
// runs the head command for SHIFT_LEN shift cycles, then pops it.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   LoadA, LoadB        - load buttons, passed to Ld_A/Ld_B only while IDLE
//   Execute             - start button; one operation per press
//   cmd (slave)         - command push channel (op_sequencer_if)
//   Ld_A, Ld_B          - register load strobes
//   Shift_En            - shift enable, high for SHIFT_LEN cycles per operation
//   F_out, R_out        - head command fields (0 when the queue is empty)
//   busy                - high in SHIFT and DONE
//   done                - one-cycle completion pulse (DONE state)
//   q_count             - entries currently queued
//   state_dbg           - current FSM state, for observation
// Build option: OP_SEQ_AUTORUN_EN - when defined, a held Execute keeps
// starting operations back to back until the queue is empty.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SHIFT_LEN = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     LoadA,
    input  logic                     LoadB,
    input  logic                     Execute,
    op_sequencer_if.slave            cmd,
    output logic                     Ld_A,
    output logic                     Ld_B,
    output logic                     Shift_En,
    output logic [F_W-1:0]           F_out,
    output logic [R_W-1:0]           R_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   q_count,
    output state_t                   state_dbg
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SHIFT_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             push;
    logic             pop;
    cmd_t             din;
    cmd_t             head;
    logic             q_empty;

    assign cmd.cmd_ready = (q_count < CW'(DEPTH));
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign din           = '{f: cmd.cmd_F, r: cmd.cmd_R};
    assign q_empty       = (q_count == '0);
    assign state_dbg     = state;

    // The head only changes on a pop in DONE, so these stay stable through SHIFT.
    assign F_out = q_empty ? '0 : head.f;
    assign R_out = q_empty ? '0 : head.r;

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (q_count)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`ifdef OP_SEQ_AUTORUN_EN
    // Queue still holds something once the DONE pop lands (a same-cycle push counts).
    logic more_after_pop;
    assign more_after_pop = (q_count > CW'(1)) || push;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        Ld_A       = 1'b0;
        Ld_B       = 1'b0;
        Shift_En   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                Ld_A = LoadA;
                Ld_B = LoadB;
                // A load button in the same cycle defers the start.
                if (Execute && !LoadA && !LoadB && !q_empty) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                Shift_En = 1'b1;
                busy     = 1'b1;
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
                pop  = 1'b1;
`ifdef OP_SEQ_AUTORUN_EN
                if (Execute && more_after_pop) begin
                    state_next = ST_SHIFT;
                end else if (Execute) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_IDLE;
                end
`else
                // Held Execute parks in HOLD so one press runs one operation.
                if (Execute) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_IDLE;
                end
`endif
            end
            ST_HOLD: begin
                if (!Execute) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_op_sequencer.sv
module tb_op_sequencer;
    import op_seq_pkg::*;

    localparam int DEPTH     = 4;
    localparam int SHIFT_LEN = 8;

    logic         Clk     = 1'b0;
    logic         Reset   = 1'b0;
    logic         LoadA   = 1'b0;
    logic         LoadB   = 1'b0;
    logic         Execute = 1'b0;
    logic         Ld_A;
    logic         Ld_B;
    logic         Shift_En;
    logic [2:0]   F_out;
    logic [1:0]   R_out;
    logic         busy;
    logic         done;
    logic [2:0]   q_count;
    state_t       state_dbg;

    int           checks   = 0;
    int           failures = 0;
    logic [4:0]   exp_q[$];

    op_sequencer_if cmd_if();

    op_sequencer #(
        .DEPTH     (DEPTH),
        .SHIFT_LEN (SHIFT_LEN)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .LoadA     (LoadA),
        .LoadB     (LoadB),
        .Execute   (Execute),
        .cmd       (cmd_if),
        .Ld_A      (Ld_A),
        .Ld_B      (Ld_B),
        .Shift_En  (Shift_En),
        .F_out     (F_out),
        .R_out     (R_out),
        .busy      (busy),
        .done      (done),
        .q_count   (q_count),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        exp_q.delete();
    endtask

    // Offers one entry for one clock; the model accepts it only if it has room.
    task automatic push_cmd(input logic [2:0] f, input logic [1:0] r);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_F     = f;
        cmd_if.cmd_R     = r;
        if (exp_q.size() < DEPTH) exp_q.push_back({f, r});
        cyc();
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Presses Execute for one cycle and observes the operation up to its done cycle.
    task automatic run_op(output int shifts, output int n, output logic [4:0] fr,
                          output logic stable, output logic tout);
        Execute = 1'b1;
        cyc();
        Execute = 1'b0;
        fr     = {F_out, R_out};
        shifts = 0;
        stable = 1'b1;
        n      = 1;
        while (done !== 1'b1 && n < 40) begin
            if (Shift_En === 1'b1) shifts++;
            if ({F_out, R_out} !== fr) stable = 1'b0;
            cyc();
            n++;
        end
        tout = (done !== 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_F = 3'b111;
        cmd_if.cmd_R = 2'b11;
        cyc();
        cyc();
        cmd_if.cmd_valid = 1'b0;
        Reset = 1'b0;
        exp_q.delete();
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_if.cmd_ready); end
        checks++; if (Shift_En !== 1'b0) begin failures++; $display("FAIL reset_shift_en got=%b exp=0", Shift_En); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({F_out, R_out} !== 5'b0) begin failures++; $display("FAIL reset_fr got=%b exp=00000", {F_out, R_out}); end
        checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    endtask

    task automatic test_single_op();
        int shifts, n;
        logic [4:0] fr;
        logic stable, tout;
        apply_reset();
        push_cmd(3'b010, 2'b00);
        checks++; if (q_count !== 3'd1) begin failures++; $display("FAIL single_q_before got=%0d exp=1", q_count); end
        checks++; if (F_out !== 3'b010) begin failures++; $display("FAIL single_idle_head got=%b exp=010", F_out); end
        run_op(shifts, n, fr, stable, tout);
        checks++; if (tout !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", tout); end
        checks++; if (shifts !== 8) begin failures++; $display("FAIL single_shift_cycles got=%0d exp=8", shifts); end
        checks++; if (n !== 9) begin failures++; $display("FAIL single_done_cycle got=%0d exp=9", n); end
        checks++; if (fr !== 5'b01000) begin failures++; $display("FAIL single_fr got=%b exp=01000", fr); end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL single_fr_stable got=%b exp=1", stable); end
        checks++; if (Shift_En !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_done_outputs shift_en=%b busy=%b exp 0/1", Shift_En, busy); end
        cyc();
        exp_q.pop_front();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0", done); end
        checks++; if (q_count !== 3'(exp_q.size())) begin failures++; $display("FAIL single_q_after got=%0d exp=%0d", q_count, exp_q.size()); end
        checks++; if (state_dbg !== ST_IDLE || F_out !== 3'b000) begin failures++; $display("FAIL single_idle_after state=%0d f=%b exp IDLE/000", state_dbg, F_out); end
    endtask

    task automatic test_full_queue();
        logic [4:0] tab [7];
        int shifts, n;
        logic [4:0] fr;
        logic stable, tout;
        tab[0] = 5'b001_01; tab[1] = 5'b110_10; tab[2] = 5'b111_11; tab[3] = 5'b100_00;
        tab[4] = 5'b010_11; tab[5] = 5'b011_10; tab[6] = 5'b101_01;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_cmd(tab[i][4:2], tab[i][1:0]);
            if (i == 3) begin
                checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready_after4 got=%b exp=0", cmd_if.cmd_ready); end
            end
        end
        checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_q_count got=%0d exp=4", q_count); end
        checks++; if ({F_out, R_out} !== 5'b001_01) begin failures++; $display("FAIL full_head got=%b exp=00101", {F_out, R_out}); end
        for (int k = 0; k < 2; k++) begin
            run_op(shifts, n, fr, stable, tout);
            checks++; if (tout !== 1'b0 || fr !== exp_q[0]) begin failures++; $display("FAIL full_op%0d_fr got=%b exp=%b tout=%b", k, fr, exp_q[0], tout); end
            cyc();
            exp_q.pop_front();
            checks++; if (q_count !== 3'(exp_q.size())) begin failures++; $display("FAIL full_op%0d_q got=%0d exp=%0d", k, q_count, exp_q.size()); end
        end
        push_cmd(tab[5][4:2], tab[5][1:0]);
        push_cmd(tab[6][4:2], tab[6][1:0]);
        checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_refill_q got=%0d exp=4", q_count); end
        for (int k = 0; k < 4; k++) begin
            run_op(shifts, n, fr, stable, tout);
            checks++; if (tout !== 1'b0 || fr !== exp_q[0] || shifts !== 8) begin failures++; $display("FAIL wrap_op%0d got=%b exp=%b shifts=%0d tout=%b", k, fr, exp_q[0], shifts, tout); end
            cyc();
            exp_q.pop_front();
        end
        checks++; if (q_count !== 3'd0 || F_out !== 3'b000) begin failures++; $display("FAIL wrap_drained q=%0d f=%b exp 0/000", q_count, F_out); end
    endtask

    task automatic test_empty_execute();
        apply_reset();
        Execute = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (Shift_En !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin failures++; $display("FAIL empty_exec c%0d shift_en=%b busy=%b state=%0d exp 0/0/IDLE", i, Shift_En, busy, state_dbg); end
        end
        Execute = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_shift();
        int dn, se;
        apply_reset();
        push_cmd(3'b001, 2'b10);
        push_cmd(3'b100, 2'b01);
        Execute = 1'b1;
        cyc();
        Execute = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (Shift_En !== 1'b1) begin failures++; $display("FAIL midrst_in_shift got=%b exp=1", Shift_En); end
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        exp_q.delete();
        checks++; if (Shift_En !== 1'b0 || q_count !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL midrst_after shift_en=%b q=%0d done=%b exp 0/0/0", Shift_En, q_count, done); end
        checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0) begin failures++; $display("FAIL midrst_state state=%0d busy=%b exp IDLE/0", state_dbg, busy); end
        dn = 0; se = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dn++;
            if (Shift_En === 1'b1) se++;
            cyc();
        end
        checks++; if (dn !== 0 || se !== 0) begin failures++; $display("FAIL midrst_quiet done_pulses=%0d shift_cycles=%0d exp 0/0", dn, se); end
    endtask

    task automatic test_execute_held();
        int shifts, dones, exp_shifts, exp_dones;
        logic [2:0] exp_q_left;
        logic [2:0] exp_f;
`ifdef OP_SEQ_AUTORUN_EN
        exp_shifts = 16; exp_dones = 2; exp_q_left = 3'd0; exp_f = 3'b000;
`else
        exp_shifts = 8;  exp_dones = 1; exp_q_left = 3'd1; exp_f = 3'b011;
`endif
        apply_reset();
        push_cmd(3'b101, 2'b10);
        push_cmd(3'b011, 2'b01);
        Execute = 1'b1;
        cyc();
        shifts = 0; dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (Shift_En === 1'b1) shifts++;
            if (done === 1'b1) dones++;
            cyc();
        end
        checks++; if (shifts !== exp_shifts) begin failures++; $display("FAIL held_shift_cycles got=%0d exp=%0d", shifts, exp_shifts); end
        checks++; if (dones !== exp_dones) begin failures++; $display("FAIL held_done_pulses got=%0d exp=%0d", dones, exp_dones); end
        checks++; if (state_dbg !== ST_HOLD || Shift_En !== 1'b0) begin failures++; $display("FAIL held_hold state=%0d shift_en=%b exp HOLD/0", state_dbg, Shift_En); end
        checks++; if (q_count !== exp_q_left || F_out !== exp_f) begin failures++; $display("FAIL held_queue q=%0d f=%b exp=%0d/%b", q_count, F_out, exp_q_left, exp_f); end
        Execute = 1'b0;
        cyc();
        checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL held_release got=%0d exp=%0d", state_dbg, ST_IDLE); end
    endtask

    task automatic test_load_priority();
        int n;
        apply_reset();
        push_cmd(3'b110, 2'b11);
        LoadA = 1'b1;
        Execute = 1'b1;
        #1;
        checks++; if (Ld_A !== 1'b1 || Ld_B !== 1'b0) begin failures++; $display("FAIL load_idle_a ld_a=%b ld_b=%b exp 1/0", Ld_A, Ld_B); end
        cyc();
        checks++; if (state_dbg !== ST_IDLE || Shift_En !== 1'b0) begin failures++; $display("FAIL load_defers state=%0d shift_en=%b exp IDLE/0", state_dbg, Shift_En); end
        LoadB = 1'b1;
        #1;
        checks++; if (Ld_A !== 1'b1 || Ld_B !== 1'b1) begin failures++; $display("FAIL load_idle_both ld_a=%b ld_b=%b exp 1/1", Ld_A, Ld_B); end
        LoadA = 1'b0;
        LoadB = 1'b0;
        cyc();
        checks++; if (Shift_En !== 1'b1) begin failures++; $display("FAIL load_then_start got=%b exp=1", Shift_En); end
        LoadA = 1'b1;
        LoadB = 1'b1;
        #1;
        checks++; if (Ld_A !== 1'b0 || Ld_B !== 1'b0) begin failures++; $display("FAIL load_in_shift ld_a=%b ld_b=%b exp 0/0", Ld_A, Ld_B); end
        Execute = 1'b0;
        LoadA = 1'b0;
        LoadB = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL load_op_done got=%b exp=1", done); end
        cyc();
        checks++; if (state_dbg !== ST_IDLE || q_count !== 3'd0) begin failures++; $display("FAIL load_op_end state=%0d q=%0d exp IDLE/0", state_dbg, q_count); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_F     = 3'b000;
        cmd_if.cmd_R     = 2'b00;
        cyc();
        test_reset();
        test_single_op();
        test_full_queue();
        test_empty_execute();
        test_reset_mid_shift();
        test_execute_held();
        test_load_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
